// File: rtl/trig_sched_pkg.sv
// Shared types and helpers for the trigger pulse scheduler and its arbiter.
// No logic of its own; latency and backpressure are defined by the users.
package trig_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_DEAD  = 2'd2
    } state_t;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit searching upward from last+1.
// Zero latency, no backpressure; the caller decides whether to take the grant.
module rr_arbiter
    import trig_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_eff,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx,
    output logic [N_REQ-1:0] o_gnt
);

    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        o_gnt = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            int j;
            j = (int'(i_last) + i) % N_REQ;
            if (!o_vld && i_eff[j]) begin
                o_vld    = 1'b1;
                o_idx    = IDX_W'(j);
                o_gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trig_pulse_scheduler.sv
// Shares one pulse output among N_REQ requesters: round-robin grant, fixed pulse, dead time.
// Request to out/grant is one cycle; requests are never stalled, overlaps are counted as drops.
module trig_pulse_scheduler
    import trig_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int P_N_WIDTH   = 16,
    parameter int P_CNT_WIDTH = 16,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       enable,
    input  logic [P_N_WIDTH-1:0]   pulse_len,
    input  logic [P_N_WIDTH-1:0]   deadtime,
    input  logic                   clr_drop,
    output logic                   out,
    output logic [IDX_W-1:0]       out_src,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [P_CNT_WIDTH-1:0] drop_cnt
);

    localparam logic [P_CNT_WIDTH+3:0] C_SAT = {4'd0, {P_CNT_WIDTH{1'b1}}};

    state_t                 r_state;
    logic [P_N_WIDTH-1:0]   r_cnt;
    logic [P_N_WIDTH-1:0]   r_len_m1;
    logic [P_N_WIDTH-1:0]   r_dead_m1;
    logic                   r_dead_nz;
    logic [IDX_W-1:0]       r_last;
    logic [N_REQ-1:0]       r_pending;
    logic                   r_out;
    logic [IDX_W-1:0]       r_out_src;
    logic [N_REQ-1:0]       r_grant;
    logic                   r_busy;
    logic [P_CNT_WIDTH-1:0] r_drop_cnt;

    logic [N_REQ-1:0]       w_eff;
    logic                   w_arb_vld;
    logic [IDX_W-1:0]       w_arb_idx;
    logic [N_REQ-1:0]       w_arb_gnt;
    logic [N_REQ-1:0]       w_take;
    logic [N_REQ-1:0]       w_drop;
    logic [N_REQ-1:0]       w_pend_nxt;
    logic [P_CNT_WIDTH+3:0] w_drop_sum;

    assign w_eff  = (r_pending | req) & enable;
    assign w_take = (r_state == S_IDLE && w_arb_vld) ? w_arb_gnt : '0;
    // A request landing on its own grant edge re-arms pending instead of dropping.
    assign w_pend_nxt = enable & ((r_pending & req & w_take) | ((r_pending | req) & ~w_take));
    assign w_drop     = req & enable & r_pending & ~w_take;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_eff  (w_eff),
        .i_last (r_last),
        .o_vld  (w_arb_vld),
        .o_idx  (w_arb_idx),
        .o_gnt  (w_arb_gnt)
    );

    always_comb begin
        w_drop_sum = {4'd0, r_drop_cnt};
        for (int i = 0; i < N_REQ; i++) begin
            if (w_drop[i]) w_drop_sum = w_drop_sum + (P_CNT_WIDTH+4)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (clr_drop)              r_drop_cnt <= '0;
            else if (w_drop_sum > C_SAT) r_drop_cnt <= '1;
            else                       r_drop_cnt <= w_drop_sum[P_CNT_WIDTH-1:0];
        end
    end

    // Counter compares against latched L-1 / D-1 so a full-scale pulse_len never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len_m1  <= '0;
            r_dead_m1 <= '0;
            r_dead_nz <= 1'b0;
            r_last    <= IDX_W'(N_REQ - 1);
            r_out     <= 1'b0;
            r_out_src <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_vld) begin
                        r_state   <= S_PULSE;
                        r_out     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_grant   <= w_arb_gnt;
                        r_out_src <= w_arb_idx;
                        r_last    <= w_arb_idx;
                        r_cnt     <= '0;
                        r_len_m1  <= (pulse_len == '0) ? '0 : pulse_len - P_N_WIDTH'(1);
                        r_dead_m1 <= deadtime - P_N_WIDTH'(1);
                        r_dead_nz <= (deadtime != '0);
                    end else begin
                        r_out  <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == r_len_m1) begin
                        r_out <= 1'b0;
                        r_cnt <= '0;
                        if (r_dead_nz) begin
                            r_state <= S_DEAD;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + P_N_WIDTH'(1);
                    end
                end
                S_DEAD: begin
                    if (r_cnt == r_dead_m1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + P_N_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out      = r_out;
    assign out_src  = r_out_src;
    assign grant    = r_grant;
    assign busy     = r_busy;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_trig_pulse_scheduler.sv
// Bench for trig_pulse_scheduler: directed scenarios plus random traffic against a
// remaining-cycles reference model, checked through an expected-output queue.
module tb_trig_pulse_scheduler;

    localparam int N_REQ = 4;
    localparam int PNW   = 16;
    localparam int PCW   = 2;
    localparam int IDX_W = 2;
    localparam int SAT   = (1 << PCW) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] enable = '0;
    logic [PNW-1:0]   pulse_len = '0;
    logic [PNW-1:0]   deadtime = '0;
    logic             clr_drop = 1'b0;
    logic             out;
    logic [IDX_W-1:0] out_src;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic [PCW-1:0]   drop_cnt;

    logic             n_rst = 1'b0;
    logic [N_REQ-1:0] n_en = '0;
    logic [PNW-1:0]   n_plen = '0;
    logic [PNW-1:0]   n_dt = '0;

    always #5 clk = ~clk;

    trig_pulse_scheduler #(.N_REQ(N_REQ), .P_N_WIDTH(PNW), .P_CNT_WIDTH(PCW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .enable    (enable),
        .pulse_len (pulse_len),
        .deadtime  (deadtime),
        .clr_drop  (clr_drop),
        .out       (out),
        .out_src   (out_src),
        .grant     (grant),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic             o;
        logic [IDX_W-1:0] src;
        logic [N_REQ-1:0] g;
        logic             b;
        logic [PCW-1:0]   d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: cycles of high and dead time still owed, plus request bookkeeping.
    int m_hi = 0, m_dead = 0, m_last = N_REQ - 1, m_src = 0, m_drop = 0;
    bit m_pend[N_REQ];

    task automatic model_step();
        exp_t e;
        int   take = -1;
        int   nd = 0;
        if (!reset_n) begin
            m_hi = 0; m_dead = 0; m_last = N_REQ - 1; m_src = 0; m_drop = 0;
            for (int i = 0; i < N_REQ; i++) m_pend[i] = 0;
        end else begin
            if (m_hi == 0 && m_dead == 0) begin
                for (int i = 1; i <= N_REQ; i++) begin
                    int j = (m_last + i) % N_REQ;
                    if (take < 0 && enable[j] && (m_pend[j] || req[j])) take = j;
                end
            end else if (m_hi > 0) begin
                m_hi--;
            end else begin
                m_dead--;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!enable[i])     m_pend[i] = 0;
                else if (i == take) m_pend[i] = m_pend[i] && req[i];
                else if (req[i]) begin
                    if (m_pend[i]) nd++;
                    m_pend[i] = 1;
                end
            end
            if (clr_drop) m_drop = 0;
            else          m_drop = (m_drop + nd > SAT) ? SAT : m_drop + nd;
            if (take >= 0) begin
                m_hi   = (pulse_len == 0) ? 1 : int'(pulse_len);
                m_dead = int'(deadtime);
                m_last = take;
                m_src  = take;
            end
        end
        e.o   = (m_hi > 0);
        e.src = IDX_W'(m_src);
        e.g   = (take >= 0) ? N_REQ'(1 << take) : '0;
        e.b   = (m_hi > 0) || (m_dead > 0);
        e.d   = PCW'(m_drop);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [N_REQ-1:0] r, input logic c = 1'b0);
        @(negedge clk);
        req       = r;
        clr_drop  = c;
        reset_n   = n_rst;
        enable    = n_en;
        pulse_len = n_plen;
        deadtime  = n_dt;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {out, out_src, grant, busy, drop_cnt};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got out=%b src=%0d grant=%b busy=%b drop=%0d exp out=%b src=%0d grant=%b busy=%b drop=%0d",
                             $time, got.o, got.src, got.g, got.b, got.d, e.o, e.src, e.g, e.b, e.d);
                end
            end
        end
    end

    initial begin
        n_rst = 1'b0; n_en = 4'hf; n_plen = 16'd5; n_dt = 16'd3;
        repeat (3) cyc('0);
        n_rst = 1'b1;
        // Single request on requester 2
        repeat (5) cyc('0);
        cyc(4'b0100);
        repeat (12) cyc('0);
        // All four at once: round-robin service
        cyc(4'b1111);
        repeat (42) cyc('0);
        // Overlapping strobes on requester 1 saturate the drop counter, then clear
        cyc(4'b0001);
        repeat (5) cyc(4'b0010);
        repeat (20) cyc('0);
        cyc('0, 1'b1);
        repeat (3) cyc('0);
        // Minimum pulse and zero dead time, back-to-back strobes
        n_plen = 16'd0; n_dt = 16'd0;
        cyc(4'b1000);
        cyc(4'b1000);
        repeat (6) cyc('0);
        // pulse_len changed mid-pulse has no effect on width
        n_plen = 16'd5; n_dt = 16'd2;
        cyc(4'b0100);
        n_plen = 16'd1;
        repeat (10) cyc('0);
        // Pending on 1 dropped by disabling it
        n_plen = 16'd4;
        cyc(4'b0011);
        n_en = 4'b1101;
        repeat (12) cyc('0);
        n_en = 4'hf;
        // Reset in the third cycle of a pulse, then re-arbitration from req[0]
        cyc(4'b0100);
        cyc('0);
        cyc('0);
        n_rst = 1'b0;
        cyc('0);
        n_rst = 1'b1;
        cyc('0);
        cyc(4'b1111);
        repeat (30) cyc('0);
        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [N_REQ-1:0] r;
            r = ($urandom_range(0, 2) == 0) ? N_REQ'($urandom) : '0;
            if ($urandom_range(0, 19) == 0) n_en = N_REQ'($urandom);
            else if ($urandom_range(0, 9) == 0) n_en = 4'hf;
            if ($urandom_range(0, 15) == 0) n_plen = PNW'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) n_dt = PNW'($urandom_range(0, 3));
            n_rst = ($urandom_range(0, 199) != 0);
            cyc(r, $urandom_range(0, 49) == 0);
        end
        n_rst = 1'b1;
        repeat (3) cyc('0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d pending entries exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trig_pulse_scheduler.md
Name: trig_pulse_scheduler

Overview:
- Shares one physical trigger/pulse output line among N_REQ requesters (discriminator, software strobe, calibration, periodic).
- Each granted request produces one fixed-length output pulse followed by an enforced dead time.
- Requesters are arbitrated round-robin; per-requester requests are buffered in pending flags.
- Overlapping requests are counted as drops.
- Sits between the trigger sources and the front-panel/LED trigger output driver.

Parameters:
- N_REQ, 4, number of requesters (2..8); IDX_W = clog2(N_REQ) is a derived localparam.
- P_N_WIDTH, 16, width of the pulse_len and deadtime configuration fields.
- P_CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  single-cycle request strobes, already synchronous to clk.
- enable  in  N_REQ  per-requester enable.
- pulse_len  in  P_N_WIDTH  output pulse length in clk cycles; 0 is treated as 1.
- deadtime  in  P_N_WIDTH  minimum low cycles after a pulse, excluding the arbitration cycle.
- clr_drop  in  1  synchronous clear of drop_cnt.
- out  out  1  shared pulse output, registered.
- out_src  out  IDX_W  index of the requester owning the current pulse; holds its last value otherwise.
- grant  out  N_REQ  one-hot, one cycle wide, coincident with the first out-high cycle.
- busy  out  1  high in PULSE and DEAD states.
- drop_cnt  out  P_CNT_WIDTH  saturating count of dropped requests.

Behaviour:
- Reset values: out=0, out_src=0, grant=0, busy=0, drop_cnt=0, pending=0, fsm=IDLE, rr pointer last=N_REQ-1 (so req[0] has priority first).
- Reset mid-pulse: out goes low on the next cycle and all state returns to reset values.
- Effective request vector: eff = (pending | req) & enable.
- Disabled requester: req is ignored (not latched, not counted). Deasserting enable[i] clears pending[i].
- FSM IDLE: if eff != 0, pick the first set bit searching from (last+1) mod N_REQ upward with wrap. In the same edge:
  - grant[k]=1, out=1, out_src=k, last=k.
  - Latch L = max(pulse_len,1) and D = deadtime.
  - Clear pending[k]; go to PULSE.
  - Otherwise remain in IDLE with out=0.
- Latency: req[k] high in cycle t while IDLE and eff otherwise 0 -> out and grant[k] high in cycle t+1.
- PULSE: out=1 for exactly L cycles, counted by an internal counter.
  - After the last cycle: go to DEAD if D>0, else IDLE.
  - Mid-pulse changes to pulse_len/deadtime have no effect; values are latched at grant.
- DEAD: out=0 for D cycles, then IDLE.
- Back-to-back pulses: minimum low gap between pulses = D+1 cycles (DEAD plus one IDLE arbitration cycle).
- Pending: in any state, req[i]&enable[i] with pending[i]=0 sets pending[i], unless it is consumed by a grant that same edge.
- Drops: req[i]&enable[i] while pending[i]=1 and pending[i] is not being granted that edge counts as a drop. pending stays 1.
- Same edge as a grant of i: if req[i] fires while its pending is being granted, pending[i] is re-set and this is not a drop.
- drop_cnt: adds popcount(drops) each cycle and saturates at 2^P_CNT_WIDTH-1. clr_drop has priority; drops in the clear cycle are lost.
- busy = (fsm != IDLE), registered with the state.
- Arithmetic: the internal counter is P_N_WIDTH wide and compares against the latched L-1 and D-1, so there is no wrap for any legal value. pulse_len=2^P_N_WIDTH-1 is legal.

Decomposition:
- Shared package trig_sched_pkg holds:
  - FSM state constants S_IDLE=0, S_PULSE=1, S_DEAD=2; default branch returns to S_IDLE.
  - The IDX_W derivation function.
- Sub-module rr_arbiter (combinational):
  - Inputs: eff vector and last index.
  - Outputs: valid, index k, one-hot grant vector.
  - Parameterised by N_REQ; reusable by the other trigger-routing blocks.
- Top-level keeps the FSM, counter, pending flags and drop counter.

Test Plan:
- Single request (N_REQ=4, L=5, D=3): req[2] strobe at cycle 10 -> grant[2] and out high in cycles 11-15, out_src=2, busy high for cycles 11-18, out low from 16, back to IDLE at 19.
- Round-robin: req=4'b1111 at cycle 10 -> grants in order 0,1,2,3. Pulse starts at 11, 20, 29, 38 (period L+D+1=9). drop_cnt=0.
- Drop and saturation (P_CNT_WIDTH=2): req[1] strobed 5 times during one pulse of requester 0 -> pending[1] set once, drop_cnt=3 (saturated). Then clr_drop -> drop_cnt=0.
- Boundary: pulse_len=0, deadtime=0, req[3] twice back-to-back -> two 1-cycle pulses separated by exactly 1 low cycle. Changing pulse_len mid-pulse leaves width unchanged.
- Enable/reset: pending[1] set, then enable[1]=0 -> no grant for 1 and pending cleared. Separately, reset_n low in cycle 3 of a pulse -> out=0 next cycle, all outputs at reset values, and the next arbitration starts at req[0].
